ap_fifo_frame_engine: RTL and testbench



---
 rtl/ap_fifo_frame_engine.sv | 180 ++++++++++++++++++
 tb/tb_ap_fifo_frame_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_fifo_frame_engine.sv
// ap_fifo_frame_engine: header + N payload frame parser with per-frame lane transform.
// Define AP_FRAME_CHECKSUM_EN to append a {bad_op, sum, cnt} trailer word per frame.
module ap_fifo_frame_engine #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 32,
    parameter int FCNT_W = 16
) (
    input  logic              ip_clk,
    input  logic              ip_rst,
    input  logic [DATA_W-1:0] in_r_dout,
    input  logic              in_r_empty_n,
    output logic              in_r_read,
    output logic [DATA_W-1:0] out_r_din,
    input  logic              out_r_full,
    output logic              out_r_write,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_count
);

    localparam int LANES = DATA_W / 32;

    typedef enum logic [1:0] {HDR, PAY, TRL} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  n_q, cnt, cnt_inc;
    logic [7:0]        op_q;
    logic [63:0]       opnd_q;
    logic [DATA_W-1:0] out_q, xf;
    logic [FCNT_W-1:0] fcnt;
    logic              out_valid, drain, space;
    logic              hdr_rd, pay_rd, pay_last, trl_done;

    assign drain    = out_valid & ~out_r_full;
    assign space    = ~out_valid | drain;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign pay_last = (cnt_inc == n_q);

    // Next-state and input handshake; header reads ignore output space
    always_comb begin
        state_nx  = state;
        in_r_read = 1'b0;
        hdr_rd    = 1'b0;
        pay_rd    = 1'b0;
        trl_done  = 1'b0;
        case (state)
            HDR: begin
                in_r_read = in_r_empty_n & ~ip_rst;
                hdr_rd    = in_r_read;
                if (hdr_rd)
                    state_nx = (in_r_dout[CNT_W-1:0] != '0) ? PAY : TRL;
            end
            PAY: begin
                in_r_read = in_r_empty_n & space;
                pay_rd    = in_r_read;
                if (pay_rd && pay_last)
                    state_nx = HDR == HDR ? TRL : TRL;
            end
            TRL: begin
`ifdef AP_FRAME_CHECKSUM_EN
                trl_done = space;
`else
                trl_done = 1'b1;
`endif
                if (trl_done)
                    state_nx = HDR;
            end
            default: state_nx = HDR;
        endcase
    end

    // Per-frame lane transform of the current input word
    always_comb begin
        xf = in_r_dout;
        case (op_q)
            8'd1: begin
                for (int i = 0; i < LANES; i++)
                    xf[32*i +: 32] = in_r_dout[32*i +: 32]
                                   ^ opnd_q[32*(i%2) +: 32];
            end
            8'd2: begin
                for (int i = 0; i < LANES; i++)
                    xf[32*i +: 32] = in_r_dout[32*i +: 32] + opnd_q[31:0];
            end
            8'd3: begin
                for (int b = 0; b < DATA_W/8; b++)
                    xf[8*b +: 8] = in_r_dout[DATA_W-8-8*b +: 8];
            end
            default: xf = in_r_dout;
        endcase
    end

    // FSM state register
    always_ff @(posedge ip_clk or posedge ip_rst) begin
        if (ip_rst)
            state <= HDR;
        else
            state <= state_nx;
    end

    // Header fields and payload word counter
    always_ff @(posedge ip_clk or posedge ip_rst) begin
        if (ip_rst) begin
            n_q    <= '0;
            op_q   <= '0;
            opnd_q <= '0;
            cnt    <= '0;
        end else if (hdr_rd) begin
            n_q    <= in_r_dout[CNT_W-1:0];
            op_q   <= in_r_dout[39:32];
            opnd_q <= in_r_dout[127:64];
            cnt    <= '0;
        end else if (pay_rd) begin
            cnt <= cnt_inc;
        end
    end

`ifdef AP_FRAME_CHECKSUM_EN
    logic [31:0]       sum, lsum;
    logic              bad_op, trl_load;
    logic [DATA_W-1:0] trl_word;

    assign trl_load = trl_done;

    // Lane sum of the transformed word and trailer assembly
    always_comb begin
        lsum = '0;
        for (int i = 0; i < LANES; i++)
            lsum = lsum + xf[32*i +: 32];
        trl_word        = '0;
        trl_word[31:0]  = 32'(cnt);
        trl_word[63:32] = sum;
        trl_word[64]    = bad_op;
    end

    // Running checksum and unknown-opcode flag
    always_ff @(posedge ip_clk or posedge ip_rst) begin
        if (ip_rst) begin
            sum    <= '0;
            bad_op <= 1'b0;
        end else if (hdr_rd) begin
            sum    <= '0;
            bad_op <= (in_r_dout[39:32] > 8'd3);
        end else if (pay_rd) begin
            sum <= sum + lsum;
        end
    end
`endif

    // Output register: a load may replace a word draining this cycle
    always_ff @(posedge ip_clk or posedge ip_rst) begin
        if (ip_rst) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else if (pay_rd) begin
            out_q     <= xf;
            out_valid <= 1'b1;
`ifdef AP_FRAME_CHECKSUM_EN
        end else if (trl_load) begin
            out_q     <= trl_word;
            out_valid <= 1'b1;
`endif
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // Completed-frame counter, wraps naturally
    always_ff @(posedge ip_clk or posedge ip_rst) begin
        if (ip_rst)
            fcnt <= '0;
        else if (trl_done)
            fcnt <= fcnt + FCNT_W'(1);
    end

    assign out_r_din   = out_q;
    assign out_r_write = drain;
    assign busy        = (state != HDR);
    assign frame_count = fcnt;

endmodule

// File: tb/tb_ap_fifo_frame_engine.sv
// tb_ap_fifo_frame_engine: directed vectors and corner sequences for ap_fifo_frame_engine.
// Trailer expectations follow AP_FRAME_CHECKSUM_EN as passed to the design.
module tb_ap_fifo_frame_engine;

    logic         ip_clk = 1'b0;
    logic         ip_rst = 1'b1;
    logic [127:0] in_r_dout = '0;
    logic         in_r_empty_n = 1'b0;
    logic         in_r_read;
    logic [127:0] out_r_din;
    logic         out_r_full = 1'b0;
    logic         out_r_write;
    logic         busy;
    logic [15:0]  frame_count;

`ifdef AP_FRAME_CHECKSUM_EN
    localparam int NTRL = 1;
`else
    localparam int NTRL = 0;
`endif

    ap_fifo_frame_engine #(.DATA_W(128), .CNT_W(32), .FCNT_W(16)) dut (
        .ip_clk(ip_clk),
        .ip_rst(ip_rst),
        .in_r_dout(in_r_dout),
        .in_r_empty_n(in_r_empty_n),
        .in_r_read(in_r_read),
        .out_r_din(out_r_din),
        .out_r_full(out_r_full),
        .out_r_write(out_r_write),
        .busy(busy),
        .frame_count(frame_count)
    );

    always #5 ip_clk = ~ip_clk;

    typedef struct {
        logic [7:0]   op;
        logic [63:0]  opnd;
        logic [127:0] pay;
        logic [127:0] exp;
        logic [31:0]  esum;
        logic         ebad;
    } vec_t;

    vec_t vt[6];

    logic [127:0] src[$];
    logic [127:0] outq[$];
    int           rdcyc[$];
    int           wrcyc[$];
    int  nvec = 0, nmis = 0;
    int  cyc = 0, nreads = 0, spurious = 0, efc = 0;
    logic rd_pending = 1'b0, gate = 1'b1;
    logic toggle = 1'b0, full_req = 1'b0, rst_req = 1'b1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] outw(input int i);
        return (i < outq.size()) ? outq[i] : 'x;
    endfunction

    function automatic logic [127:0] hdr(input logic [31:0] n,
                                         input logic [7:0] op,
                                         input logic [63:0] opnd);
        return {opnd, 24'h0, op, n};
    endfunction

    task automatic tick();
        @(negedge ip_clk);
        if (rd_pending && src.size() > 0)
            src.delete(0);
        ip_rst       = rst_req;
        gate         = toggle ? ~gate : 1'b1;
        in_r_empty_n = gate && (src.size() > 0);
        in_r_dout    = (src.size() > 0) ? src[0] : '0;
        out_r_full   = full_req;
        #1;
        rd_pending = in_r_read;
        if (in_r_read) begin
            rdcyc.push_back(cyc);
            nreads++;
        end
        if (in_r_read && !in_r_empty_n)
            spurious++;
        if (out_r_write) begin
            outq.push_back(out_r_din);
            wrcyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic run_idle(input string nm, input int budget);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while ((src.size() > 0 || busy || rd_pending) && k < budget);
        repeat (3) tick();
        nvec++;
        if (k >= budget) begin
            nmis++;
            $display("FAIL %s: timeout after %0d cycles, want idle", nm, k);
        end
    endtask

    initial begin
        int base, bad, k;
        logic [127:0] wa, wb;

        vt[0] = '{8'd0, 64'h1111, 128'h0123456789ABCDEF_FEDCBA9876543210,
                  128'h0123456789ABCDEF_FEDCBA9876543210, 32'hFFFFFFFE, 1'b0};
        vt[1] = '{8'd1, 64'h0F0F0F0F_F0F0F0F0,
                  128'hFFFFFFFF_00000000_FFFFFFFF_00000000,
                  128'hF0F0F0F0_F0F0F0F0_F0F0F0F0_F0F0F0F0, 32'hC3C3C3C0, 1'b0};
        vt[2] = '{8'd2, 64'h10, 128'h00000001_FFFFFFF8_7FFFFFFF_00000000,
                  128'h00000011_00000008_8000000F_00000010, 32'h80000038, 1'b0};
        vt[3] = '{8'd3, 64'h0, 128'h00010203_04050607_08090A0B_0C0D0E0F,
                  128'h0F0E0D0C_0B0A0908_07060504_03020100, 32'h24201C18, 1'b0};
        vt[4] = '{8'h7F, 64'h55, 128'h1234, 128'h1234, 32'h1234, 1'b1};
        vt[5] = '{8'hFF, 64'hFFFF, 128'hA, 128'hA, 32'hA, 1'b1};

        repeat (3) tick();
        chk("rst_read", in_r_read, 0);
        chk("rst_write", out_r_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_din", out_r_din, 0);
        rst_req = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            outq.delete();
            src.push_back(hdr(1, vt[v].op, vt[v].opnd));
            src.push_back(vt[v].pay);
            run_idle($sformatf("vec%0d_done", v), 40);
            efc++;
            chk($sformatf("vec%0d_nw", v), outq.size(), 1 + NTRL);
            chk($sformatf("vec%0d_data", v), outw(0), vt[v].exp);
`ifdef AP_FRAME_CHECKSUM_EN
            chk($sformatf("vec%0d_trl", v), outw(1),
                {63'b0, vt[v].ebad, vt[v].esum, 32'd1});
`endif
            chk($sformatf("vec%0d_fc", v), frame_count, efc);
        end

        outq.delete();
        rdcyc.delete();
        wrcyc.delete();
        src.push_back(hdr(2, 8'd1, 64'hFFFF0000_FFFF0000));
        src.push_back(128'h0);
        src.push_back('1);
        run_idle("xor_done", 40);
        efc++;
        chk("xor_nw", outq.size(), 2 + NTRL);
        chk("xor_w0", outw(0), {2{64'hFFFF0000_FFFF0000}});
        chk("xor_w1", outw(1), {2{64'h0000FFFF_0000FFFF}});
`ifdef AP_FRAME_CHECKSUM_EN
        chk("xor_trl", outw(2), {64'h0, 32'hFFFFFFFC, 32'd2});
`endif
        chk("xor_lat0", wrcyc[0], rdcyc[1] + 1);
        chk("xor_lat1", wrcyc[1], rdcyc[2] + 1);
        chk("xor_fc", frame_count, efc);

        outq.delete();
        src.push_back(hdr(0, 8'd0, 64'h0));
        run_idle("n0_done", 20);
        efc++;
        chk("n0_nw", outq.size(), NTRL);
`ifdef AP_FRAME_CHECKSUM_EN
        chk("n0_trl", outw(0), 128'h0);
`endif
        chk("n0_busy", busy, 0);
        chk("n0_fc", frame_count, efc);

        outq.delete();
        full_req = 1'b1;
        base = nreads;
        src.push_back(hdr(4, 8'd2, 64'h1));
        for (int i = 0; i < 4; i++)
            src.push_back('1);
        repeat (14) tick();
        chk("bp_reads", nreads - base, 2);
        chk("bp_nowrite", outq.size(), 0);
        full_req = 1'b0;
        run_idle("bp_done", 40);
        efc++;
        chk("bp_nw", outq.size(), 4 + NTRL);
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (outw(i) !== 128'h0)
                bad++;
        chk("bp_wrap", bad, 0);
`ifdef AP_FRAME_CHECKSUM_EN
        chk("bp_trl", outw(4), 128'h4);
`endif

        outq.delete();
        wa = 128'hA5A50001;
        wb = 128'h5A5A0002;
        full_req = 1'b1;
        src.push_back(hdr(2, 8'd0, 64'h0));
        src.push_back(wa);
        src.push_back(wb);
        repeat (6) tick();
        chk("hold_din", out_r_din, wa);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_r_din !== wa || out_r_write || in_r_read)
                bad++;
        end
        chk("hold_stable", bad, 0);
        full_req = 1'b0;
        run_idle("hold_done", 40);
        efc++;
        chk("hold_w0", outw(0), wa);
        chk("hold_w1", outw(1), wb);
`ifdef AP_FRAME_CHECKSUM_EN
        chk("hold_trl", outw(2), {64'h0, 32'hFFFF0003, 32'd2});
`endif

        outq.delete();
        spurious = 0;
        toggle = 1'b1;
        src.push_back(hdr(3, 8'd0, 64'h0));
        src.push_back(128'h11);
        src.push_back(128'h22);
        src.push_back(128'h33);
        run_idle("tog_done", 60);
        toggle = 1'b0;
        efc++;
        chk("tog_nw", outq.size(), 3 + NTRL);
        chk("tog_w0", outw(0), 128'h11);
        chk("tog_w1", outw(1), 128'h22);
        chk("tog_w2", outw(2), 128'h33);
        chk("tog_spur", spurious, 0);
        chk("tog_fc", frame_count, efc);

        outq.delete();
        base = nreads;
        src.push_back(hdr(3, 8'd0, 64'h0));
        src.push_back(128'hC1);
        src.push_back(128'hC2);
        src.push_back(128'hC3);
        k = 0;
        while (nreads - base < 2 && k < 20) begin
            tick();
            k++;
        end
        chk("mrst_pre", nreads - base, 2);
        rst_req = 1'b1;
        tick();
        src.delete();
        outq.delete();
        src.push_back(hdr(1, 8'd0, 64'h0));
        src.push_back(128'hBEEF);
        repeat (3) tick();
        efc = 0;
        chk("mrst_read", in_r_read, 0);
        chk("mrst_write", out_r_write, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_din", out_r_din, 0);
        chk("mrst_fc", frame_count, efc);
        rst_req = 1'b0;
        run_idle("mrst_done", 40);
        efc++;
        chk("mrst_nw", outq.size(), 1 + NTRL);
        chk("mrst_w0", outw(0), 128'hBEEF);
`ifdef AP_FRAME_CHECKSUM_EN
        chk("mrst_trl", outw(1), {64'h0, 32'hBEEF, 32'd1});
`endif
        chk("mrst_fc1", frame_count, efc);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
